// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants and types for the register-file writeback port arbiter.
// Source encoding matches src_o; REG_ZERO is the hardwired-zero register.
package wb_port_arbiter_pkg;
    localparam int AW = 5;
    localparam int DW = 32;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    localparam logic [AW-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;
endpackage

// File: rtl/wb_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant gated by en, zero latency.
// The pointer names the side preferred on a tie and moves to the loser after every grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);
    logic rr_ptr_q;
    logic rr_ptr_d;

    // rr_ptr_q = 0 prefers req[0] (A), 1 prefers req[1] (B)
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req[0] && (!req[1] || !rr_ptr_q)) begin
                gnt = 2'b01;
            end else if (req[1]) begin
                gnt = 2'b10;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt[0]) begin
            rr_ptr_d = 1'b1;
        end else if (gnt[1]) begin
            rr_ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates A/B writebacks into one registered slot feeding the regfile; accept-to-write 1 cycle.
// Slot holds while stall_i is high; requests are refused only while the slot is full and stalled.
module wb_port_arbiter #(
    parameter int AW = wb_port_arbiter_pkg::AW,
    parameter int DW = wb_port_arbiter_pkg::DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_data,
    input  logic          b_valid,
    output logic          b_ready,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_data,
    input  logic          stall_i,
    output logic          we_o,
    output logic [AW-1:0] waddr_o,
    output logic [DW-1:0] wdata_o,
    output logic          src_o
);
    import wb_port_arbiter_pkg::*;

    slot_state_t   state_q, state_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          src_q, src_d;

    logic          out_valid;
    logic          free;
    logic          arb_en;
    logic [1:0]    gnt;
    logic          accept;
    logic          load;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;
    logic          sel_src;

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req ({b_valid, a_valid}),
        .en  (arb_en),
        .gnt (gnt)
    );

    // Outputs: we_o and the readies are combinational; holding rst masks the readies.
    always_comb begin
        out_valid = (state_q == SLOT_FULL);
        we_o      = out_valid & ~stall_i;
        free      = ~out_valid | ~stall_i;
        arb_en    = free & ~rst;
        a_ready   = free & gnt[0];
        b_ready   = free & gnt[1];
        waddr_o   = waddr_q;
        wdata_o   = wdata_q;
        src_o     = src_q;
    end

    // A granted $0 write completes its handshake but never occupies the slot.
    always_comb begin
        accept   = a_ready | b_ready;
        sel_src  = b_ready ? SRC_B : SRC_A;
        sel_addr = b_ready ? b_addr : a_addr;
        sel_data = b_ready ? b_data : a_data;
        load     = accept & (sel_addr != AW'(REG_ZERO));
        waddr_d  = load ? sel_addr : waddr_q;
        wdata_d  = load ? sel_data : wdata_q;
        src_d    = load ? sel_src  : src_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SLOT_EMPTY: if (load) state_d = SLOT_FULL;
            SLOT_FULL: begin
                if (load) begin
                    state_d = SLOT_FULL;
                end else if (we_o) begin
                    state_d = SLOT_EMPTY;
                end
            end
            default: state_d = SLOT_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
            waddr_q <= '0;
            wdata_q <= '0;
            src_q   <= SRC_A;
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            src_q   <= src_d;
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;
    logic        clk;
    logic        rst;
    logic        a_valid, a_ready, b_valid, b_ready;
    logic [4:0]  a_addr, b_addr, waddr_o;
    logic [31:0] a_data, b_data, wdata_o;
    logic        stall_i, we_o, src_o;

    wb_port_arbiter #(.AW(5), .DW(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .a_addr  (a_addr),
        .a_data  (a_data),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .b_addr  (b_addr),
        .b_data  (b_data),
        .stall_i (stall_i),
        .we_o    (we_o),
        .waddr_o (waddr_o),
        .wdata_o (wdata_o),
        .src_o   (src_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        src;
    } wr_t;

    // Reference: pending writes awaiting the regfile, tie preference, and two regfile images.
    wr_t         pend_q[$];
    bit          pref_b;
    logic [31:0] model_rf [32];
    logic [31:0] dut_rf   [32];

    int n_chk = 0;
    int n_err = 0;
    bit g_a, g_b;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive at negedge, check at negedge+1, advance the reference at posedge.
    task automatic cycle(input bit av, input logic [4:0] aa, input logic [31:0] ad,
                         input bit bv, input logic [4:0] ba, input logic [31:0] bd,
                         input bit st, output bit ga, output bit gb);
        bit  busy, free, exp_we;
        wr_t w;
        @(negedge clk);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        stall_i = st;
        #1;
        busy   = (pend_q.size() != 0);
        exp_we = busy && !st;
        free   = !busy || !st;
        ga     = free && av && (!bv || !pref_b);
        gb     = free && bv && (!av || pref_b);
        check_val("we_o", {31'd0, we_o}, {31'd0, exp_we});
        check_val("a_ready", {31'd0, a_ready}, {31'd0, ga});
        check_val("b_ready", {31'd0, b_ready}, {31'd0, gb});
        if (busy) begin
            check_val("waddr_o", {27'd0, waddr_o}, {27'd0, pend_q[0].addr});
            check_val("wdata_o", wdata_o, pend_q[0].data);
            check_val("src_o", {31'd0, src_o}, {31'd0, pend_q[0].src});
        end
        if (we_o === 1'b1) dut_rf[waddr_o] = wdata_o;
        @(posedge clk);
        if (exp_we) begin
            model_rf[pend_q[0].addr] = pend_q[0].data;
            void'(pend_q.pop_front());
        end
        if (ga || gb) begin
            pref_b = ga;
            w.addr = gb ? ba : aa;
            w.data = gb ? bd : ad;
            w.src  = gb;
            if (w.addr != 5'd0) pend_q.push_back(w);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, g_a, g_b);
    endtask

    bit          rav, rbv, rst_st;
    logic [4:0]  raa, rba;
    logic [31:0] rad, rbd;

    initial begin
        for (int i = 0; i < 32; i++) begin
            model_rf[i] = 32'd0;
            dut_rf[i]   = 32'd0;
        end
        pref_b = 1'b0;
        rst = 1'b1;
        a_valid = 1'b1; a_addr = 5'd4; a_data = 32'h5;
        b_valid = 1'b1; b_addr = 5'd6; b_data = 32'h7;
        stall_i = 1'b0;
        #2;
        check_val("rst_we_o", {31'd0, we_o}, 32'd0);
        check_val("rst_a_ready", {31'd0, a_ready}, 32'd0);
        check_val("rst_b_ready", {31'd0, b_ready}, 32'd0);
        check_val("rst_waddr", {27'd0, waddr_o}, 32'd0);
        check_val("rst_wdata", wdata_o, 32'd0);
        check_val("rst_src", {31'd0, src_o}, 32'd0);
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        rst = 1'b0;

        // Single A write, then alternating dual requests.
        cycle(1, 5'd8, 32'h1234_5678, 0, 5'd0, 32'd0, 0, g_a, g_b);
        idle(2);
        for (int i = 0; i < 4; i++) cycle(1, 5'd1, 32'hA, 1, 5'd2, 32'hB, 0, g_a, g_b);
        idle(2);

        // B fills the slot, then a 3-cycle stall with A waiting.
        cycle(0, 5'd0, 32'd0, 1, 5'd3, 32'h33, 0, g_a, g_b);
        for (int i = 0; i < 3; i++) cycle(1, 5'd5, 32'h55, 0, 5'd0, 32'd0, 1, g_a, g_b);
        cycle(1, 5'd5, 32'h55, 0, 5'd0, 32'd0, 0, g_a, g_b);
        idle(2);

        // Point the tie at A, then a $0 write racing B.
        cycle(0, 5'd0, 32'd0, 1, 5'd13, 32'hD, 0, g_a, g_b);
        cycle(1, 5'd0, 32'hFFFF_FFFF, 1, 5'd14, 32'hE, 0, g_a, g_b);
        cycle(0, 5'd0, 32'd0, 1, 5'd14, 32'hE, 0, g_a, g_b);
        idle(2);

        // Tie at B, both target r9: B's data lands first, A's is final.
        cycle(1, 5'd10, 32'h10, 0, 5'd0, 32'd0, 0, g_a, g_b);
        cycle(1, 5'd9, 32'h1, 1, 5'd9, 32'h2, 0, g_a, g_b);
        cycle(1, 5'd9, 32'h1, 0, 5'd0, 32'd0, 0, g_a, g_b);
        idle(2);
        check_val("r9_final", dut_rf[9], 32'h1);
        check_val("r0_untouched", dut_rf[0], 32'd0);

        rav = 0; rbv = 0;
        raa = 0; rba = 0; rad = 0; rbd = 0;
        for (int n = 0; n < 600; n++) begin
            if (!rav) begin
                rav = ($urandom_range(0, 3) != 0);
                raa = 5'($urandom_range(0, 12));
                rad = $urandom;
            end
            if (!rbv) begin
                rbv = ($urandom_range(0, 3) != 0);
                rba = 5'($urandom_range(0, 12));
                rbd = $urandom;
            end
            rst_st = ($urandom_range(0, 3) == 0);
            cycle(rav, raa, rad, rbv, rba, rbd, rst_st, g_a, g_b);
            if (g_a) rav = 0;
            if (g_b) rbv = 0;
        end
        idle(3);

        // Asynchronous reset while the slot is full and writing.
        cycle(1, 5'd7, 32'h77, 0, 5'd0, 32'd0, 0, g_a, g_b);
        #1;
        check_val("pre_rst_we_o", {31'd0, we_o}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_val("async_rst_we_o", {31'd0, we_o}, 32'd0);
        check_val("async_rst_waddr", {27'd0, waddr_o}, 32'd0);
        check_val("async_rst_wdata", wdata_o, 32'd0);
        a_valid = 1'b0; b_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        pend_q.delete();
        pref_b = 1'b0;
        cycle(1, 5'd11, 32'hB1, 1, 5'd12, 32'hC2, 0, g_a, g_b);
        cycle(0, 5'd0, 32'd0, 1, 5'd12, 32'hC2, 0, g_a, g_b);
        idle(2);
        check_val("post_rst_r11", dut_rf[11], 32'hB1);

        for (int i = 0; i < 32; i++) check_val("regfile", dut_rf[i], model_rf[i]);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
